// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake, operands and results of the iterative divider.
//   master : the requester. It drives start, signed_op, dividend and divisor.
//            It reads busy, done, div_by_zero, quotient, remainder and result.
//   slave  : the divider. It reads the request signals and drives the status and result signals.
//   WIDTH must match the WIDTH of the seq_divider that is connected.
interface seq_divider_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic                 signed_op;
   logic [WIDTH-1:0]     dividend;
   logic [WIDTH-1:0]     divisor;
   logic                 busy;
   logic                 done;
   logic                 div_by_zero;
   logic [WIDTH-1:0]     quotient;
   logic [WIDTH-1:0]     remainder;
   logic [2*WIDTH-1:0]   result;

   modport master (
      output start, signed_op, dividend, divisor,
      input  busy, done, div_by_zero, quotient, remainder, result
   );

   modport slave (
      input  start, signed_op, dividend, divisor,
      output busy, done, div_by_zero, quotient, remainder, result
   );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring integer divider for the Mini SRC ALU.
// The result is packed {remainder, quotient}. Z-high therefore loads HI and Z-low loads LO.
//
// Ports:
//   clock : system clock. All state updates on the rising edge.
//   clear : asynchronous, active-high reset.
//   dif   : seq_divider_if.slave. It carries start, signed_op, dividend and divisor (inputs)
//           and busy, done, div_by_zero, quotient, remainder and result (outputs).
//
// Build option:
//   DIV_SIGNED_EN : when defined, signed_op selects a two's-complement divide.
//                   When undefined, every divide is unsigned. Latency does not change.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; results hold their last values
// CALC   | one restoring shift/subtract step per cycle, WIDTH steps
// FIX    | negate quotient/remainder according to the latched signs
// DONE   | publish results; done pulses on the following cycle
module seq_divider #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic        clock,
   input  logic        clear,
   seq_divider_if.slave dif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

`ifdef DIV_SIGNED_EN
   localparam logic SIGNED_EN = 1'b1;
`else
   localparam logic SIGNED_EN = 1'b0;
`endif

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] r_work;
   logic [WIDTH-1:0] q_work;
   logic [WIDTH-1:0] d_mag;
   logic             q_neg;
   logic             r_neg;
   logic             dz_pend;

   logic             signed_eff;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   trial;

   assign signed_eff = dif.signed_op & SIGNED_EN;
   assign a_neg      = signed_eff & dif.dividend[WIDTH-1];
   assign b_neg      = signed_eff & dif.divisor[WIDTH-1];
   // The magnitude of the most-negative value is 2^(WIDTH-1). It still fits unsigned.
   assign a_mag      = a_neg ? -dif.dividend : dif.dividend;
   assign b_mag      = b_neg ? -dif.divisor  : dif.divisor;

   // The partial remainder is shifted with the next dividend bit from the top of q_work.
   // It is compared against the divisor in WIDTH+1 bits, so the carry-out acts as the sign.
   assign r_shift    = {r_work, q_work[WIDTH-1]};
   assign trial      = r_shift - {1'b0, d_mag};

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state           <= S_IDLE;
         cnt             <= '0;
         r_work          <= '0;
         q_work          <= '0;
         d_mag           <= '0;
         q_neg           <= 1'b0;
         r_neg           <= 1'b0;
         dz_pend         <= 1'b0;
         dif.busy        <= 1'b0;
         dif.done        <= 1'b0;
         dif.div_by_zero <= 1'b0;
         dif.quotient    <= '0;
         dif.remainder   <= '0;
         dif.result      <= '0;
      end else begin
         dif.done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (dif.start) begin
                  q_neg           <= a_neg ^ b_neg;
                  r_neg           <= a_neg;
                  cnt             <= CNT_W'(WIDTH);
                  dif.busy        <= 1'b1;
                  dif.div_by_zero <= 1'b0;
                  if (dif.divisor == '0) begin
                     // Divide by zero: all-ones quotient, raw dividend as remainder.
                     dz_pend <= 1'b1;
                     q_work  <= '1;
                     r_work  <= dif.dividend;
                     d_mag   <= '0;
                     state   <= S_DONE;
                  end else begin
                     dz_pend <= 1'b0;
                     q_work  <= a_mag;
                     r_work  <= '0;
                     d_mag   <= b_mag;
                     state   <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (!trial[WIDTH]) begin
                  r_work <= trial[WIDTH-1:0];
                  q_work <= {q_work[WIDTH-2:0], 1'b1};
               end else begin
                  r_work <= r_shift[WIDTH-1:0];
                  q_work <= {q_work[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= S_FIX;
               end
            end
            S_FIX: begin
               if (q_neg) q_work <= -q_work;
               if (r_neg) r_work <= -r_work;
               dif.busy <= 1'b0;
               state    <= S_DONE;
            end
            S_DONE: begin
               dif.quotient    <= q_work;
               dif.remainder   <= r_work;
               dif.result      <= {r_work, q_work};
               dif.div_by_zero <= dz_pend;
               dif.done        <= 1'b1;
               dif.busy        <= 1'b0;
               state           <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider. It drives a 32-bit and an 8-bit instance from a single clock.
// It checks every result, latency and busy duration against an arithmetic reference.
module tb_seq_divider;

`ifdef DIV_SIGNED_EN
   localparam bit SEN = 1'b1;
`else
   localparam bit SEN = 1'b0;
`endif

   logic clock = 1'b0;
   logic clear = 1'b1;
   always #5 clock = ~clock;

   seq_divider_if #(.WIDTH(32)) d32 ();
   seq_divider_if #(.WIDTH(8))  d8  ();

   seq_divider #(.WIDTH(32)) dut32 (.clock(clock), .clear(clear), .dif(d32.slave));
   seq_divider #(.WIDTH(8))  dut8  (.clock(clock), .clear(clear), .dif(d8.slave));

   typedef struct {
      logic [63:0] q;
      logic [63:0] r;
      bit          dz;
      int          lat;
      int          busy;
      int          t0;
   } exp_t;

   exp_t sb32[$];
   exp_t sb8[$];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int busy32_cnt = 0;
   int busy8_cnt  = 0;

   always @(posedge clock) cyc++;

   task automatic check(string name, logic [63:0] act, logic [63:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
      end
   endtask

   // The reference model uses plain integer division. SystemVerilog '/' and '%' truncate toward zero.
   function automatic void model(int w, bit sgn, logic [63:0] a, logic [63:0] b,
                                 output logic [63:0] q, output logic [63:0] r, output bit dz);
      logic [63:0] mask;
      longint      sa, sb;
      mask = (64'd1 << w) - 64'd1;
      dz   = 1'b0;
      if (b == 64'd0) begin
         q  = mask;
         r  = a;
         dz = 1'b1;
      end else if (sgn && SEN) begin
         sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
         sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
         q  = 64'(sa / sb) & mask;
         r  = 64'(sa % sb) & mask;
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   always @(negedge clock) begin
      exp_t e;
      if (clear) begin
         busy32_cnt = 0;
      end else begin
         if (d32.busy) busy32_cnt++;
         if (d32.done) begin
            if (sb32.size() == 0) begin
               check("unexpected_done32", 64'd1, 64'd0);
            end else begin
               e = sb32.pop_front();
               check("quotient32",  64'(d32.quotient),  e.q);
               check("remainder32", 64'(d32.remainder), e.r);
               check("result32",    64'(d32.result),    {e.r[31:0], e.q[31:0]});
               check("dbz32",       64'(d32.div_by_zero), 64'(e.dz));
               check("latency32",   64'(cyc - e.t0),    64'(e.lat));
               check("busy_len32",  64'(busy32_cnt),    64'(e.busy));
            end
            busy32_cnt = 0;
         end
      end
   end

   always @(negedge clock) begin
      exp_t e;
      if (clear) begin
         busy8_cnt = 0;
      end else begin
         if (d8.busy) busy8_cnt++;
         if (d8.done) begin
            if (sb8.size() == 0) begin
               check("unexpected_done8", 64'd1, 64'd0);
            end else begin
               e = sb8.pop_front();
               check("quotient8",  64'(d8.quotient),  e.q);
               check("remainder8", 64'(d8.remainder), e.r);
               check("result8",    64'(d8.result),    {48'd0, e.r[7:0], e.q[7:0]});
               check("dbz8",       64'(d8.div_by_zero), 64'(e.dz));
               check("latency8",   64'(cyc - e.t0),   64'(e.lat));
               check("busy_len8",  64'(busy8_cnt),    64'(e.busy));
            end
            busy8_cnt = 0;
         end
      end
   end

   // Pulse start for one cycle and push the expected response. The operands are then scrambled.
   task automatic issue(bit w8, bit sgn, logic [31:0] a, logic [31:0] b);
      exp_t e;
      int   w;
      w = w8 ? 8 : 32;
      if (w8) begin
         a = a & 32'hFF;
         b = b & 32'hFF;
      end
      @(negedge clock);
      model(w, sgn, 64'(a), 64'(b), e.q, e.r, e.dz);
      // Start is accepted at the next edge. Done is sampled on the negedge after edge w+2 (or edge 1).
      e.lat  = e.dz ? 2 : w + 3;
      e.busy = e.dz ? 1 : w + 1;
      e.t0   = cyc;
      if (w8) begin
         d8.start = 1'b1; d8.signed_op = sgn; d8.dividend = a[7:0]; d8.divisor = b[7:0];
         sb8.push_back(e);
      end else begin
         d32.start = 1'b1; d32.signed_op = sgn; d32.dividend = a; d32.divisor = b;
         sb32.push_back(e);
      end
      @(negedge clock);
      if (w8) begin
         d8.start = 1'b0; d8.dividend = 8'($urandom); d8.divisor = 8'($urandom);
         d8.signed_op = 1'($urandom);
      end else begin
         d32.start = 1'b0; d32.dividend = $urandom; d32.divisor = $urandom;
         d32.signed_op = 1'($urandom);
      end
   endtask

   task automatic wait_drain(string name);
      int n;
      n = 0;
      while ((sb32.size() != 0 || sb8.size() != 0) && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (sb32.size() != 0 || sb8.size() != 0) begin
         check({name, "_timeout"}, 64'd1, 64'd0);
         sb32.delete();
         sb8.delete();
      end
   endtask

   task automatic check_zero(string name);
      check({name, "_busy32"}, 64'(d32.busy), 64'd0);
      check({name, "_done32"}, 64'(d32.done), 64'd0);
      check({name, "_dbz32"},  64'(d32.div_by_zero), 64'd0);
      check({name, "_q32"},    64'(d32.quotient), 64'd0);
      check({name, "_r32"},    64'(d32.remainder), 64'd0);
      check({name, "_res32"},  64'(d32.result), 64'd0);
      check({name, "_busy8"},  64'(d8.busy), 64'd0);
      check({name, "_res8"},   64'(d8.result), 64'd0);
   endtask

   function automatic logic [31:0] pick(int mode, bit lo);
      case (mode)
         0:       return lo ? 32'h8000_0000 : 32'hFFFF_FFFF;
         1:       return 32'($urandom_range(0, 300));
         2:       return lo ? 32'($urandom_range(0, 15)) - 32'd8 : $urandom;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      d32.start = 1'b0; d32.signed_op = 1'b0; d32.dividend = '0; d32.divisor = '0;
      d8.start  = 1'b0; d8.signed_op  = 1'b0; d8.dividend  = '0; d8.divisor  = '0;
      #12;
      check_zero("reset");
      @(negedge clock);
      clear = 1'b0;

      issue(1'b0, 1'b0, 32'd6, 32'd4);
      wait_drain("u6_4");
      issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_drain("s_m7_2");
      issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_drain("mn_m1");

      // Divide by zero. The flag must stay set while idle and clear on the next accepted start.
      issue(1'b0, 1'b0, 32'h1234, 32'd0);
      wait_drain("dz");
      repeat (3) @(negedge clock);
      check("dbz_hold", 64'(d32.div_by_zero), 64'd1);
      issue(1'b0, 1'b0, 32'd9, 32'd3);
      check("dbz_cleared", 64'(d32.div_by_zero), 64'd0);
      wait_drain("after_dz");

      // A second start while busy must not disturb the running 100/7.
      issue(1'b0, 1'b0, 32'd100, 32'd7);
      repeat (3) @(negedge clock);
      d32.start = 1'b1; d32.dividend = 32'd9; d32.divisor = 32'd3;
      @(negedge clock);
      d32.start = 1'b0;
      wait_drain("ignore_start");

      // Abort with clear. No done may follow: the monitor flags any done with an empty scoreboard.
      @(negedge clock);
      d32.start = 1'b1; d32.signed_op = 1'b0; d32.dividend = 32'd100; d32.divisor = 32'd7;
      @(negedge clock);
      d32.start = 1'b0;
      repeat (4) @(negedge clock);
      d32.start = 1'b1; d32.dividend = 32'd9; d32.divisor = 32'd3;
      @(negedge clock);
      d32.start = 1'b0;
      repeat (14) @(negedge clock);
      check("busy_before_clear", 64'(d32.busy), 64'd1);
      clear = 1'b1;
      #1;
      check_zero("abort");
      @(negedge clock);
      clear = 1'b0;
      repeat (40) @(negedge clock);
      check("no_done_after_clear", 64'(d32.busy), 64'd0);
      issue(1'b0, 1'b0, 32'd9, 32'd3);
      wait_drain("after_clear");

      issue(1'b1, 1'b0, 32'd255, 32'd16);
      wait_drain("w8_255_16");
      issue(1'b1, 1'b1, 32'h80, 32'hFF);
      wait_drain("w8_mn_m1");

      for (int i = 0; i < 40; i++) begin
         int m;
         logic [31:0] a, b;
         m = $urandom_range(0, 5);
         a = pick(m, 1'b1);
         b = (m == 4) ? 32'd0 : pick(m, 1'b0);
         issue(1'b0, 1'($urandom), a, b);
         wait_drain("rand32");
      end
      for (int i = 0; i < 30; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom_range(0, 255);
         issue(1'b1, 1'($urandom), a, b);
         wait_drain("rand8");
      end

      repeat (5) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
